dac_spi: RTL and testbench



---
 rtl/dac_spi_pkg.sv | 14 +
 rtl/dac_spi.sv | 120 ++++++++++++
 tb/tb_dac_spi.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dac_spi_pkg.sv
// rtl/dac_spi_pkg.sv - shared state type and default parameters for the DAC SPI master
package dac_spi_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_GAP
   } dac_state_t;

   localparam int DAC_DATA_W     = 16;
   localparam int DAC_CLK_DIV    = 4;
   localparam int DAC_GAP_CYCLES = 2;

endpackage

// File: rtl/dac_spi.sv
// rtl/dac_spi.sv - write-only SPI master sending one DATA_W-bit word per wr strobe, MSB first
module dac_spi
   import dac_spi_pkg::*;
#(
   parameter int DATA_W     = DAC_DATA_W,
   parameter int CLK_DIV    = DAC_CLK_DIV,
   parameter int GAP_CYCLES = DAC_GAP_CYCLES
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              wr,
   output logic              spi_cs_n,
   output logic              spi_sclk,
   output logic              spi_sdout
);

   localparam int FRAME = DATA_W * CLK_DIV;
   localparam int CNT_W = $clog2(FRAME);

   localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME - 1);
   localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV        = CNT_W'(CLK_DIV);
   localparam logic [CNT_W-1:0] HALF       = CNT_W'(CLK_DIV / 2);

   dac_state_t        state, state_n;
   logic [CNT_W-1:0]  cnt, cnt_n, cnt_inc, phase;
   logic [DATA_W-1:0] shreg, shreg_n;
   logic              cs_n_q, cs_n_n;
   logic              sclk_q, sclk_n;
   logic              sdout_q, sdout_n;
   logic              accept;

   assign cnt_inc = cnt + 1'b1;
   assign phase   = cnt_inc % DIV;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         shreg   <= '0;
         cs_n_q  <= 1'b1;
         sclk_q  <= 1'b1;
         sdout_q <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         shreg   <= shreg_n;
         cs_n_q  <= cs_n_n;
         sclk_q  <= sclk_n;
         sdout_q <= sdout_n;
      end
   end

   // Output registers are computed for the cycle that follows the edge, so
   // the pins reflect the position cnt_n rather than the current cnt.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      shreg_n = shreg;
      cs_n_n  = cs_n_q;
      sclk_n  = sclk_q;
      sdout_n = sdout_q;
      accept  = 1'b0;

      case (state)
         ST_IDLE: begin
            accept = wr;
         end
         ST_SHIFT: begin
            if (cnt == FRAME_LAST) begin
               state_n = ST_GAP;
               cnt_n   = '0;
               cs_n_n  = 1'b1;
               sclk_n  = 1'b1;
               sdout_n = 1'b0;
            end else begin
               cnt_n  = cnt_inc;
               sclk_n = (phase < HALF);
               if (phase == '0) begin
                  // Rotate rather than shift so the register MSB is always the bit on the pin.
                  shreg_n = {shreg[DATA_W-2:0], shreg[DATA_W-1]};
                  sdout_n = shreg[DATA_W-2];
               end
            end
         end
         ST_GAP: begin
            if (cnt == GAP_LAST) begin
               state_n = ST_IDLE;
               cnt_n   = '0;
               accept  = wr;
            end else begin
               cnt_n = cnt_inc;
            end
         end
         default: begin
            state_n = ST_IDLE;
            cnt_n   = '0;
            cs_n_n  = 1'b1;
            sclk_n  = 1'b1;
            sdout_n = 1'b0;
         end
      endcase

      // The last gap cycle doubles as the first idle cycle, keeping back-to-back gaps at GAP_CYCLES.
      if (accept) begin
         state_n = ST_SHIFT;
         cnt_n   = '0;
         shreg_n = wr_data;
         cs_n_n  = 1'b0;
         sclk_n  = 1'b1;
         sdout_n = wr_data[DATA_W-1];
      end
   end

   assign spi_cs_n  = cs_n_q;
   assign spi_sclk  = sclk_q;
   assign spi_sdout = sdout_q;

endmodule

// File: tb/tb_dac_spi.sv
// tb/tb_dac_spi.sv - scoreboard bench for dac_spi: frame shape, data, busy ignore, back-to-back, reset
module tb_dac_spi;
   import dac_spi_pkg::*;

   localparam int DW = DAC_DATA_W;

   typedef struct {
      logic [DW-1:0] word;
      int            low_len;
      int            falls;
      int            ones;
      int            gap;
   } frame_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [DW-1:0] wr_data = '0;
   logic          wr = 1'b0;
   logic          spi_cs_n, spi_sclk, spi_sdout;

   int            checks = 0;
   int            errors = 0;
   int            fall_total = 0;
   int            frames_total = 0;
   logic [DW-1:0] exp_q[$];
   frame_t        got_q[$];

   dac_spi dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_data   (wr_data),
      .wr        (wr),
      .spi_cs_n  (spi_cs_n),
      .spi_sclk  (spi_sclk),
      .spi_sdout (spi_sdout)
   );

   initial forever #5 clk = ~clk;

   // Pin monitor: reassembles frames from the pins, sampling on the falling clk edge.
   initial begin
      frame_t cur;
      logic   prev_cs, prev_sclk, in_frame;
      int     hi_run;
      cur = '{default: 0};
      prev_cs = 1'b1; prev_sclk = 1'b1; in_frame = 1'b0; hi_run = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            in_frame = 1'b0; prev_cs = 1'b1; prev_sclk = 1'b1; hi_run = 0;
         end else begin
            if (prev_sclk && !spi_sclk) fall_total++;
            if (prev_cs && !spi_cs_n) begin
               in_frame = 1'b1;
               cur = '{default: 0};
               cur.gap = hi_run;
            end
            if (!spi_cs_n) begin
               hi_run = 0;
               cur.low_len++;
               if (spi_sdout) cur.ones++;
               if (prev_sclk && !spi_sclk) begin
                  cur.word = {cur.word[DW-2:0], spi_sdout};
                  cur.falls++;
               end
            end else begin
               hi_run++;
               if (!prev_cs && in_frame) begin
                  got_q.push_back(cur);
                  frames_total++;
               end
               in_frame = 1'b0;
            end
            prev_cs = spi_cs_n;
            prev_sclk = spi_sclk;
         end
      end
   end

   task automatic wait_frame(output frame_t f, output logic [DW-1:0] e, output bit ok);
      for (int i = 0; i < 400; i++) begin
         if (got_q.size() != 0) break;
         @(negedge clk);
      end
      ok = (got_q.size() != 0) && (exp_q.size() != 0);
      f = '{default: 0};
      e = '0;
      if (got_q.size() != 0) f = got_q.pop_front();
      if (exp_q.size() != 0) e = exp_q.pop_front();
   endtask

   task automatic send_word(input logic [DW-1:0] w);
      @(negedge clk);
      wr_data = w; wr = 1'b1;
      exp_q.push_back(w);
      @(negedge clk);
      wr = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if ({spi_cs_n, spi_sclk, spi_sdout} !== 3'b110) begin
            errors++;
            $display("FAIL reset_hold: cs/sclk/sdout=%b required 110", {spi_cs_n, spi_sclk, spi_sdout});
         end
      end
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         checks++;
         if ({spi_cs_n, spi_sclk, spi_sdout} !== 3'b110) begin
            errors++;
            $display("FAIL reset_release: cs/sclk/sdout=%b required 110", {spi_cs_n, spi_sclk, spi_sdout});
         end
      end
   endtask

   task automatic test_frame();
      frame_t f; logic [DW-1:0] e; bit ok;
      @(negedge clk);
      wr_data = 16'hA6CD; wr = 1'b1;
      exp_q.push_back(16'hA6CD);
      @(negedge clk);
      checks++;
      if ({spi_cs_n, spi_sclk, spi_sdout} !== 3'b011) begin
         errors++;
         $display("FAIL frame_start: cs/sclk/sdout=%b required 011", {spi_cs_n, spi_sclk, spi_sdout});
      end
      @(negedge clk);
      wr = 1'b0;
      repeat (4) @(negedge clk);
      checks++;
      if (spi_sdout !== 1'b0) begin
         errors++; $display("FAIL bit14_e5: sdout=%b required 0", spi_sdout);
      end
      repeat (4) @(negedge clk);
      checks++;
      if (spi_sdout !== 1'b1) begin
         errors++; $display("FAIL bit13_e9: sdout=%b required 1", spi_sdout);
      end
      wait_frame(f, e, ok);
      checks++;
      if (!ok || f.word !== e || f.low_len != 64 || f.falls != 16 || f.ones != $countones(e) * DAC_CLK_DIV) begin
         errors++;
         $display("FAIL frame_a6cd: ok=%0d word=%h len=%0d falls=%0d ones=%0d required word=%h len=64 falls=16 ones=%0d",
                  ok, f.word, f.low_len, f.falls, f.ones, e, $countones(e) * DAC_CLK_DIV);
      end
   endtask

   task automatic test_busy_ignore();
      frame_t f; logic [DW-1:0] e; bit ok; int base;
      @(negedge clk);
      wr_data = 16'hA6CD; wr = 1'b1;
      exp_q.push_back(16'hA6CD);
      @(negedge clk);
      wr = 1'b0;
      repeat (19) @(negedge clk);
      wr_data = 16'h1234; wr = 1'b1;
      @(negedge clk);
      wr = 1'b0;
      wait_frame(f, e, ok);
      base = frames_total;
      checks++;
      if (!ok || f.word !== e || f.low_len != 64) begin
         errors++;
         $display("FAIL busy_frame: ok=%0d word=%h len=%0d required word=%h len=64", ok, f.word, f.low_len, e);
      end
      repeat (150) @(negedge clk);
      checks++;
      if (frames_total != base || spi_cs_n !== 1'b1) begin
         errors++;
         $display("FAIL busy_no_second: frames=%0d cs_n=%b required frames=%0d cs_n=1", frames_total, spi_cs_n, base);
      end
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] words [3];
      frame_t f; logic [DW-1:0] e; bit ok;
      words[0] = 16'h5A5A; words[1] = 16'hC3F0; words[2] = 16'h0F81;
      @(negedge clk);
      wr_data = words[0]; wr = 1'b1;
      exp_q.push_back(words[0]);
      @(negedge clk);
      for (int i = 1; i < 3; i++) begin
         wr_data = words[i];
         exp_q.push_back(words[i]);
         repeat (66) @(negedge clk);
      end
      wr = 1'b0;
      for (int i = 0; i < 3; i++) begin
         wait_frame(f, e, ok);
         checks++;
         if (!ok || f.word !== e || f.low_len != 64 || f.falls != 16) begin
            errors++;
            $display("FAIL b2b_frame%0d: ok=%0d word=%h len=%0d falls=%0d required word=%h len=64 falls=16",
                     i, ok, f.word, f.low_len, f.falls, e);
         end
         if (i > 0) begin
            checks++;
            if (f.gap != DAC_GAP_CYCLES) begin
               errors++; $display("FAIL b2b_gap%0d: gap=%0d required %0d", i, f.gap, DAC_GAP_CYCLES);
            end
         end
      end
   endtask

   task automatic test_mid_reset();
      int base;
      @(negedge clk);
      wr_data = 16'hFFFF; wr = 1'b1;
      @(negedge clk);
      wr = 1'b0;
      repeat (30) @(negedge clk);
      checks++;
      if ({spi_cs_n, spi_sclk} !== 2'b00) begin
         errors++; $display("FAIL pre_reset_e30: cs/sclk=%b required 00", {spi_cs_n, spi_sclk});
      end
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if ({spi_cs_n, spi_sclk, spi_sdout} !== 3'b110) begin
         errors++;
         $display("FAIL async_reset: cs/sclk/sdout=%b required 110", {spi_cs_n, spi_sclk, spi_sdout});
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      base = fall_total;
      repeat (100) @(negedge clk);
      checks++;
      if (fall_total != base || got_q.size() != 0 || spi_cs_n !== 1'b1) begin
         errors++;
         $display("FAIL post_reset_quiet: falls=%0d frames=%0d cs_n=%b required falls=%0d frames=0 cs_n=1",
                  fall_total, got_q.size(), spi_cs_n, base);
      end
   endtask

   task automatic test_walking();
      frame_t f; logic [DW-1:0] e; bit ok;
      send_word(16'h8000);
      wait_frame(f, e, ok);
      checks++;
      if (!ok || f.word !== e || f.ones != DAC_CLK_DIV) begin
         errors++; $display("FAIL walk_8000: word=%h ones=%0d required word=%h ones=%0d", f.word, f.ones, e, DAC_CLK_DIV);
      end
      repeat (5) @(negedge clk);
      send_word(16'h0001);
      wait_frame(f, e, ok);
      checks++;
      if (!ok || f.word !== e || f.ones != DAC_CLK_DIV) begin
         errors++; $display("FAIL walk_0001: word=%h ones=%0d required word=%h ones=%0d", f.word, f.ones, e, DAC_CLK_DIV);
      end
      checks++;
      if ({spi_cs_n, spi_sclk, spi_sdout} !== 3'b110) begin
         errors++; $display("FAIL idle_after: cs/sclk/sdout=%b required 110", {spi_cs_n, spi_sclk, spi_sdout});
      end
   endtask

   initial begin
      test_reset();
      test_frame();
      repeat (10) @(negedge clk);
      test_busy_ignore();
      test_back_to_back();
      repeat (10) @(negedge clk);
      test_mid_reset();
      test_walking();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
